// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader
// Description : Byte-stream program-memory loader for the PIC16C55 core.
//               Accepts a framed image (SYNC, CNT_HI, CNT_LO, N x {LO,HI},
//               CSUM) over a valid/ready byte interface, writes 12-bit
//               instruction words into program memory and holds the core
//               in reset until the frame checksum verifies.
//               Optional inactivity timeout: define LOADER_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module prog_loader #(
  parameter int         INST_WIDTH     = 12,
  parameter int         ADDR_WIDTH     = 9,
  parameter int         DEPTH          = 512,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         RELEASE_DLY    = 4,
  parameter int         HOLD_AT_RESET  = 1,
  parameter int         TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  rx_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [INST_WIDTH-1:0] mem_wdata,
  output logic                  core_rst_n,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [1:0]            err_code
);

  // States CNT_HI..CSUM are contiguous so the timeout window is a range test.
  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_CNT_HI  = 4'd1,
    S_CNT_LO  = 4'd2,
    S_W_LO    = 4'd3,
    S_W_HI    = 4'd4,
    S_WRITE   = 4'd5,
    S_CSUM    = 4'd6,
    S_RELEASE = 4'd7,
    S_DONE    = 4'd8,
    S_ERR     = 4'd9
  } state_t;

  localparam int   c_dlyWidth     = (RELEASE_DLY > 1) ? $clog2(RELEASE_DLY) : 1;
  localparam logic c_coreRstInit  = (HOLD_AT_RESET == 0) ? 1'b1 : 1'b0;
  localparam logic [1:0] c_errNone  = 2'd0;
  localparam logic [1:0] c_errCount = 2'd1;
  localparam logic [1:0] c_errCsum  = 2'd2;

  state_t                r_state,    w_nextState;
  logic [7:0]            r_sum,      w_nextSum;
  logic [ADDR_WIDTH-1:0] r_addr,     w_nextAddr;
  logic [15:0]           r_remain,   w_nextRemain;
  logic [7:0]            r_cntHi,    w_nextCntHi;
  logic [7:0]            r_lo,       w_nextLo;
  logic [INST_WIDTH-1:0] r_wdata,    w_nextWdata;
  logic [c_dlyWidth-1:0] r_dly,      w_nextDly;
  logic                  r_coreRstN, w_nextCoreRstN;
  logic                  r_busy,     w_nextBusy;
  logic                  r_done,     w_nextDone;
  logic                  r_error,    w_nextError;
  logic [1:0]            r_errCode,  w_nextErrCode;

  logic                  w_accept;
  logic [15:0]           w_count;
  logic [7:0]            w_sumAdd;

`ifdef LOADER_TIMEOUT_EN
  localparam int         c_idleWidth = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [1:0] c_errTime   = 2'd3;
  logic [c_idleWidth-1:0] r_idle, w_nextIdle;
`endif

  // Bytes are refused only while a word is being written or the core release is pending.
  assign rx_ready   = (r_state != S_WRITE) && (r_state != S_RELEASE);
  assign w_accept   = rx_valid && rx_ready;
  assign w_count    = {r_cntHi, rx_data};
  assign w_sumAdd   = r_sum + rx_data;

  assign mem_we     = (r_state == S_WRITE);
  assign mem_addr   = r_addr;
  assign mem_wdata  = r_wdata;
  assign core_rst_n = r_coreRstN;
  assign busy       = r_busy;
  assign done       = r_done;
  assign error      = r_error;
  assign err_code   = r_errCode;

  // State and datapath registers; rst returns everything to idle at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_sum      <= '0;
      r_addr     <= '0;
      r_remain   <= '0;
      r_cntHi    <= '0;
      r_lo       <= '0;
      r_wdata    <= '0;
      r_dly      <= '0;
      r_coreRstN <= c_coreRstInit;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_errCode  <= c_errNone;
    end else begin
      r_state    <= w_nextState;
      r_sum      <= w_nextSum;
      r_addr     <= w_nextAddr;
      r_remain   <= w_nextRemain;
      r_cntHi    <= w_nextCntHi;
      r_lo       <= w_nextLo;
      r_wdata    <= w_nextWdata;
      r_dly      <= w_nextDly;
      r_coreRstN <= w_nextCoreRstN;
      r_busy     <= w_nextBusy;
      r_done     <= w_nextDone;
      r_error    <= w_nextError;
      r_errCode  <= w_nextErrCode;
    end
  end

`ifdef LOADER_TIMEOUT_EN
  // Inactivity counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idle <= '0;
    end else begin
      r_idle <= w_nextIdle;
    end
  end
`endif

  // Next-state and datapath updates for the frame parser.
  always_comb begin
    w_nextState    = r_state;
    w_nextSum      = r_sum;
    w_nextAddr     = r_addr;
    w_nextRemain   = r_remain;
    w_nextCntHi    = r_cntHi;
    w_nextLo       = r_lo;
    w_nextWdata    = r_wdata;
    w_nextDly      = r_dly;
    w_nextCoreRstN = r_coreRstN;
    w_nextBusy     = r_busy;
    w_nextDone     = r_done;
    w_nextError    = r_error;
    w_nextErrCode  = r_errCode;
`ifdef LOADER_TIMEOUT_EN
    w_nextIdle     = '0;
`endif

    case (r_state)
      S_IDLE, S_DONE, S_ERR: begin
        // Only the sync marker starts a frame; anything else is dropped.
        if (w_accept && (rx_data == SYNC_BYTE)) begin
          w_nextState    = S_CNT_HI;
          w_nextSum      = '0;
          w_nextAddr     = '0;
          w_nextDly      = '0;
          w_nextBusy     = 1'b1;
          w_nextDone     = 1'b0;
          w_nextError    = 1'b0;
          w_nextErrCode  = c_errNone;
          w_nextCoreRstN = 1'b0;
        end
      end
      S_CNT_HI: begin
        if (w_accept) begin
          w_nextCntHi = rx_data;
          w_nextSum   = w_sumAdd;
          w_nextState = S_CNT_LO;
        end
      end
      S_CNT_LO: begin
        if (w_accept) begin
          w_nextSum = w_sumAdd;
          // Rejecting oversize counts here keeps mem_addr inside DEPTH.
          if ((w_count == 16'd0) || (w_count > 16'(DEPTH))) begin
            w_nextState   = S_ERR;
            w_nextBusy    = 1'b0;
            w_nextError   = 1'b1;
            w_nextErrCode = c_errCount;
          end else begin
            w_nextRemain = w_count;
            w_nextState  = S_W_LO;
          end
        end
      end
      S_W_LO: begin
        if (w_accept) begin
          w_nextLo    = rx_data;
          w_nextSum   = w_sumAdd;
          w_nextState = S_W_HI;
        end
      end
      S_W_HI: begin
        if (w_accept) begin
          // Upper nibble of the HI byte is not part of the instruction word.
          w_nextWdata = {rx_data[INST_WIDTH-9:0], r_lo};
          w_nextSum   = w_sumAdd;
          w_nextState = S_WRITE;
        end
      end
      S_WRITE: begin
        w_nextAddr   = r_addr + ADDR_WIDTH'(1);
        w_nextRemain = r_remain - 16'd1;
        w_nextState  = (r_remain == 16'd1) ? S_CSUM : S_W_LO;
      end
      S_CSUM: begin
        if (w_accept) begin
          w_nextSum = w_sumAdd;
          if (w_sumAdd == 8'd0) begin
            w_nextState = S_RELEASE;
            w_nextDly   = '0;
          end else begin
            w_nextState   = S_ERR;
            w_nextBusy    = 1'b0;
            w_nextError   = 1'b1;
            w_nextErrCode = c_errCsum;
          end
        end
      end
      S_RELEASE: begin
        if (r_dly == c_dlyWidth'(RELEASE_DLY - 1)) begin
          w_nextState    = S_DONE;
          w_nextCoreRstN = 1'b1;
          w_nextDone     = 1'b1;
          w_nextBusy     = 1'b0;
        end else begin
          w_nextDly = r_dly + c_dlyWidth'(1);
        end
      end
      default: begin
        w_nextState = S_IDLE;
      end
    endcase

`ifdef LOADER_TIMEOUT_EN
    // A stalled frame aborts once the line has been quiet too long.
    if ((r_state >= S_CNT_HI) && (r_state <= S_CSUM)) begin
      if (w_accept) begin
        w_nextIdle = '0;
      end else if (r_idle == c_idleWidth'(TIMEOUT_CYCLES - 1)) begin
        w_nextIdle     = '0;
        w_nextState    = S_ERR;
        w_nextBusy     = 1'b0;
        w_nextError    = 1'b1;
        w_nextErrCode  = c_errTime;
        w_nextCoreRstN = 1'b0;
      end else begin
        w_nextIdle = r_idle + c_idleWidth'(1);
      end
    end
`endif
  end

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_prog_loader
// Description : Directed self-checking bench for prog_loader. Frames are
//               sent byte by byte; memory writes are logged by a monitor
//               and compared against hand-computed words.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready;
  logic        mem_we;
  logic [8:0]  mem_addr;
  logic [11:0] mem_wdata;
  logic        core_rst_n;
  logic        busy;
  logic        done;
  logic        error;
  logic [1:0]  err_code;

  int checks = 0;
  int errors = 0;

  int          weCount = 0;
  logic [8:0]  weAddr[$];
  logic [11:0] weData[$];

  prog_loader #(
    .INST_WIDTH    (12),
    .ADDR_WIDTH    (9),
    .DEPTH         (512),
    .SYNC_BYTE     (8'hA5),
    .RELEASE_DLY   (4),
    .HOLD_AT_RESET (1),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .core_rst_n(core_rst_n),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .err_code  (err_code)
  );

  always #5 clk = ~clk;

  // Log every program-memory write, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst && mem_we) begin
      weCount = weCount + 1;
      weAddr.push_back(mem_addr);
      weData.push_back(mem_wdata);
    end
  end

  task automatic do_reset();
    rx_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Present one byte and hold it until accepted (bounded).
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) begin
      checks++; errors++;
      $display("FAIL send_byte_stall byte=%h got_ready=%b exp=1", b, rx_ready);
    end else begin
      @(posedge clk);
      #1;
    end
    rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    int base;
    do_reset();
    checks++; if (core_rst_n !== 1'b0) begin errors++; $display("FAIL reset_core_rst_n got=%b exp=0", core_rst_n); end
    checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL reset_rx_ready got=%b exp=1", rx_ready); end
    checks++; if ({done, error, busy} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b exp=000", {done, error, busy}); end
    checks++; if ({mem_we, mem_addr, mem_wdata, err_code} !== 24'd0) begin errors++; $display("FAIL reset_mem got=%h exp=0", {mem_we, mem_addr, mem_wdata, err_code}); end
    base = weCount;
    send_byte(8'h00);
    send_byte(8'h12);
    repeat (3) @(negedge clk);
    checks++; if (weCount - base !== 0) begin errors++; $display("FAIL idle_ignore_we got=%0d exp=0", weCount - base); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_ignore_busy got=%b exp=0", busy); end
  endtask

  task automatic test_single_word();
    int base, n;
    base = weCount;
    send_byte(8'hA5);
    checks++; if ({busy, core_rst_n} !== 2'b10) begin errors++; $display("FAIL single_sync got=%b exp=10", {busy, core_rst_n}); end
    send_byte(8'h00); send_byte(8'h01); send_byte(8'hC5); send_byte(8'h00); send_byte(8'h3A);
    checks++; if ({rx_ready, core_rst_n, busy} !== 3'b001) begin errors++; $display("FAIL single_release_enter got=%b exp=001", {rx_ready, core_rst_n, busy}); end
    n = 0;
    while (core_rst_n !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    checks++; if (n !== 4) begin errors++; $display("FAIL single_release_dly got=%0d exp=4", n); end
    checks++; if ({done, busy, error} !== 3'b100) begin errors++; $display("FAIL single_done got=%b exp=100", {done, busy, error}); end
    checks++; if (weCount - base !== 1) begin errors++; $display("FAIL single_we_count got=%0d exp=1", weCount - base); end
    if (weCount - base >= 1) begin
      checks++; if ({weAddr[base], weData[base]} !== {9'd0, 12'h0C5}) begin errors++; $display("FAIL single_word got=%h/%h exp=000/0c5", weAddr[base], weData[base]); end
    end
  endtask

  // Starts straight from DONE to exercise a back-to-back frame.
  task automatic test_two_words();
    int base, n;
    base = weCount;
    send_byte(8'hA5);
    checks++; if ({done, core_rst_n, busy} !== 3'b001) begin errors++; $display("FAIL two_restart got=%b exp=001", {done, core_rst_n, busy}); end
    send_byte(8'h00); send_byte(8'h02);
    send_byte(8'hFF); send_byte(8'h1F);
    send_byte(8'h01); send_byte(8'hF0);
    send_byte(8'hEF);
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    checks++; if ({done, error, core_rst_n} !== 3'b101) begin errors++; $display("FAIL two_done got=%b exp=101", {done, error, core_rst_n}); end
    checks++; if (weCount - base !== 2) begin errors++; $display("FAIL two_we_count got=%0d exp=2", weCount - base); end
    if (weCount - base >= 2) begin
      checks++; if ({weAddr[base], weData[base]} !== {9'd0, 12'hFFF}) begin errors++; $display("FAIL two_word0 got=%h/%h exp=000/fff", weAddr[base], weData[base]); end
      checks++; if ({weAddr[base+1], weData[base+1]} !== {9'd1, 12'h001}) begin errors++; $display("FAIL two_word1 got=%h/%h exp=001/001", weAddr[base+1], weData[base+1]); end
    end
  endtask

  task automatic test_bad_csum();
    do_reset();
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
    send_byte(8'hC5); send_byte(8'h00); send_byte(8'h3B);
    repeat (6) @(negedge clk);
    checks++; if ({error, err_code} !== 3'b110) begin errors++; $display("FAIL csum_err got=%b exp=110", {error, err_code}); end
    checks++; if ({core_rst_n, busy, done} !== 3'b000) begin errors++; $display("FAIL csum_flags got=%b exp=000", {core_rst_n, busy, done}); end
    send_byte(8'hA5);
    checks++; if ({error, err_code, busy} !== 4'b0001) begin errors++; $display("FAIL csum_resync got=%b exp=0001", {error, err_code, busy}); end
  endtask

  task automatic test_bad_count();
    int base;
    do_reset();
    base = weCount;
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
    checks++; if ({error, err_code, busy} !== 4'b1010) begin errors++; $display("FAIL count_zero got=%b exp=1010", {error, err_code, busy}); end
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h01);
    checks++; if ({error, err_code, busy} !== 4'b1010) begin errors++; $display("FAIL count_513 got=%b exp=1010", {error, err_code, busy}); end
    repeat (3) @(negedge clk);
    checks++; if (weCount - base !== 0) begin errors++; $display("FAIL count_no_we got=%0d exp=0", weCount - base); end
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
    checks++; if ({error, busy} !== 2'b01) begin errors++; $display("FAIL count_512_ok got=%b exp=01", {error, busy}); end
  endtask

  task automatic test_mid_reset();
    int base;
    do_reset();
    base = weCount;
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h11); send_byte(8'h02);
    repeat (2) @(negedge clk);
    checks++; if ({weCount - base, mem_addr} !== {32'd1, 9'd1}) begin errors++; $display("FAIL midrst_first_word got=%0d/%h exp=1/001", weCount - base, mem_addr); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({core_rst_n, busy, done, error, mem_we, rx_ready} !== 6'b000001) begin errors++; $display("FAIL midrst_flags got=%b exp=000001", {core_rst_n, busy, done, error, mem_we, rx_ready}); end
    checks++; if ({mem_addr, mem_wdata, err_code} !== 23'd0) begin errors++; $display("FAIL midrst_mem got=%h exp=0", {mem_addr, mem_wdata, err_code}); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (weCount - base !== 1) begin errors++; $display("FAIL midrst_no_we got=%0d exp=1", weCount - base); end
  endtask

`ifdef LOADER_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    do_reset();
    send_byte(8'hA5); send_byte(8'h00);
    repeat (8) @(negedge clk);
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL timeout_early got=%b exp=0", error); end
    n = 0;
    while (error !== 1'b1 && n < 40) begin
      @(negedge clk); n++;
    end
    checks++; if ({error, err_code, core_rst_n, busy} !== 5'b11100) begin errors++; $display("FAIL timeout_err got=%b exp=11100", {error, err_code, core_rst_n, busy}); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_word();
    test_two_words();
    test_bad_csum();
    test_bad_count();
    test_mid_reset();
`ifdef LOADER_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Byte-stream program-memory loader that sits directly upstream of the PIC16C55 core.
- Receives a framed image over a valid/ready byte interface and writes 12-bit instruction words into program memory.
- Holds the core in reset while loading and releases it only after the frame checksum verifies.
- Provides the only write path into program memory and drives the core's rst_n.

Parameters:
- INST_WIDTH, 12, instruction word width.
- ADDR_WIDTH, 9, program memory address width.
- DEPTH, 512, maximum words per image.
- SYNC_BYTE, 8'hA5, frame start marker.
- RELEASE_DLY, 4, cycles between checksum pass and core_rst_n rising.
- HOLD_AT_RESET, 1, 1 = core_rst_n held low after reset until a valid image loads; 0 = core released after reset.
- TIMEOUT_CYCLES, 1024, inactivity limit (optional feature only).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- rx_valid  in  1  input byte valid.
- rx_data  in  8  input byte.
- rx_ready  out  1  loader accepts byte; a transfer occurs when rx_valid && rx_ready.
- mem_we  out  1  program memory write strobe, one cycle.
- mem_addr  out  ADDR_WIDTH  write address.
- mem_wdata  out  INST_WIDTH  write data.
- core_rst_n  out  1  active-low reset to the core.
- busy  out  1  frame in progress.
- done  out  1  last frame loaded and verified (level).
- error  out  1  last frame failed (level).
- err_code  out  2  0 none, 1 bad count, 2 checksum, 3 timeout.

Behaviour:
- Reset values:
  - state IDLE; rx_ready=1; mem_we=0; mem_addr=0; mem_wdata=0.
  - busy=0; done=0; error=0; err_code=0.
  - core_rst_n = ~HOLD_AT_RESET.
- Frame format: SYNC, CNT_HI, CNT_LO (N words, big-endian), N × {LO, HI}, CSUM.
  - Word = {HI[3:0], LO}. HI[7:4] is ignored.
  - CSUM makes the 8-bit sum of CNT_HI, CNT_LO, all word bytes and CSUM equal 0.
- States: IDLE, CNT_HI, CNT_LO, W_LO, W_HI, WRITE, CSUM, RELEASE, DONE, ERR.
- IDLE, DONE, ERR:
  - rx_ready=1.
  - Accepting SYNC_BYTE moves to CNT_HI, sets busy=1, clears done/error/err_code, drives core_rst_n=0, and resets the running sum and address.
  - Non-sync bytes are discarded.
- CNT_HI → CNT_LO; CNT_LO → W_LO.
  - If N==0 or N>DEPTH at CNT_LO acceptance: go to ERR, err_code=1.
- W_LO → W_HI. W_HI → WRITE.
- WRITE:
  - One cycle; mem_we=1, rx_ready=0.
  - mem_addr = current address; the address increments after the write.
  - Goes to W_LO, or to CSUM once N words are written.
- CSUM:
  - On acceptance, if the total sum is 0 go to RELEASE, else go to ERR with err_code=2.
- RELEASE:
  - rx_ready=0; counts RELEASE_DLY cycles, then core_rst_n=1, done=1, busy=0, state DONE.
- ERR:
  - busy=0, error=1, core_rst_n stays 0.
  - Memory contents are undefined; a new SYNC restarts the load.
- Transfers are only counted when rx_valid && rx_ready. Bytes are not accepted in WRITE or RELEASE.
- mem_addr wraps modulo 2^ADDR_WIDTH. It cannot exceed DEPTH-1 because the count is checked.
- rst asserted mid-frame: immediate return to the reset values. No partial mem_we may occur after rst rises.

Optional Feature:
- Macro LOADER_TIMEOUT_EN.
- Defined: in states CNT_HI through CSUM, an inactivity counter clears on every accepted byte and increments otherwise. Reaching TIMEOUT_CYCLES goes to ERR with err_code=3, core_rst_n=0.
- Undefined: no counter; the loader waits indefinitely. err_code=3 never occurs.

Test Plan:
- Reset with HOLD_AT_RESET=1 → core_rst_n=0, rx_ready=1, done=0, error=0. Bytes 00,12 sent in IDLE → ignored, no mem_we.
- Frame A5 00 01 C5 00 3A → one mem_we with addr 0, wdata 12'h0C5. Then after RELEASE_DLY=4 cycles: core_rst_n=1, done=1, busy=0.
- Frame A5 00 02 FF 1F 01 F0 CSUM=0xEF → writes addr0=12'hFFF, addr1=12'h001 (HI[7:4] dropped). done=1.
- Same frame as the 0x0C5 case but CSUM=0x3B → error=1, err_code=2, core_rst_n stays 0. Sending A5 next clears error and sets busy=1.
- Count 00 00, or 02 01 with DEPTH=512 → ERR immediately after CNT_LO, err_code=1, no mem_we.
- rst pulsed after the first word is written → outputs return to reset values. With LOADER_TIMEOUT_EN and TIMEOUT_CYCLES=16, stalling after CNT_HI for 16 cycles → err_code=3.
